// File: rtl/mario_pkg.sv
// Shared level-object definitions: spawn table entry layout, tile geometry and
// the spawner state encoding.
package mario_pkg;

  localparam logic [7:0] SPAWN_END = 8'hFF;
  localparam logic [9:0] TILE_W    = 10'd40;

  typedef struct packed {
    logic [7:0] col;
    logic [9:0] y;
  } spawn_entry_t;

  localparam int unsigned ENTRY_W = $bits(spawn_entry_t);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } spawner_state_t;

endpackage

// File: rtl/spawn_table_rom.sv
// Level spawn table: DEPTH entries baked in from INIT (entry i at bits
// [i*ENTRY_W +: ENTRY_W]), read with one cycle of registered latency.
module spawn_table_rom
  import mario_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [DEPTH*ENTRY_W-1:0] INIT = {DEPTH{SPAWN_END, 10'd0}}
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] addr,
  output spawn_entry_t      data
);

  spawn_entry_t rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = spawn_entry_t'(INIT[i*ENTRY_W +: ENTRY_W]);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin : rom_read
    if (!Reset_n) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/goomba_spawner.sv
// Goomba spawn controller: walks the level spawn table as the screen scrolls,
// hands each entry to the lowest free goomba slot, and tallies squished goombas.
module goomba_spawner
  import mario_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned TABLE_DEPTH = 16,
  parameter logic [7:0]  SCREEN_COLS = 8'd10,
  parameter logic [9:0]  SPAWN_X     = 10'(13 * TILE_W - 10'd1),
  parameter logic [3:0]  ACK_TIMEOUT = 4'd8,
  parameter logic [TABLE_DEPTH*ENTRY_W-1:0] TABLE_INIT = {TABLE_DEPTH{SPAWN_END, 10'd0}}
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 level_start,
  input  logic                 kill_all,
  input  logic                 Shift,
  input  logic [NUM_SLOTS-1:0] goomba_alive,
  input  logic [NUM_SLOTS-1:0] goomba_killed,
  output logic [NUM_SLOTS-1:0] start,
  output logic [NUM_SLOTS-1:0] kill,
  output logic [9:0]           spawnX,
  output logic [9:0]           spawnY,
  output logic [7:0]           kill_count,
  output logic                 table_done,
  output logic                 spawn_err
);

  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned ADDR_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TABLE_DEPTH - 1);
  localparam logic [7:0]        SCROLL_MAX = 8'hFE;

  spawner_state_t       state;
  logic [ADDR_W-1:0]    ptr;
  logic [7:0]           scroll_col;
  logic [SLOT_W-1:0]    slot;
  logic [NUM_SLOTS-1:0] pend;
  logic [3:0]           timer;
  spawn_entry_t         entry;

  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;
  logic                 at_end;
  logic                 too_far;
  logic [3:0]           killed_now;
  logic [8:0]           kill_sum;

  spawn_table_rom #(
    .DEPTH  (TABLE_DEPTH),
    .ADDR_W (ADDR_W),
    .INIT   (TABLE_INIT)
  ) u_rom (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .addr    (ptr),
    .data    (entry)
  );

  // Lowest-index slot that is dead and not the one still waiting to come alive.
  always_comb begin : free_slot_enc
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!goomba_alive[i] && !pend[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  // The last address is reserved for the terminator even if the table omits it.
  assign at_end  = (entry.col == SPAWN_END) || (ptr == LAST_ADDR);
  assign too_far = {1'b0, entry.col} > ({1'b0, scroll_col} + {1'b0, SCREEN_COLS});

  always_comb begin : kill_popcount
    killed_now = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      killed_now = killed_now + 4'(goomba_killed[i]);
    end
    kill_sum = {1'b0, kill_count} + 9'(killed_now);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin : kill_tally
    if (!Reset_n) begin
      kill_count <= '0;
    end else if (kill_sum[8]) begin
      kill_count <= 8'hFF;
    end else begin
      kill_count <= kill_sum[7:0];
    end
  end

  // Scroll position stops one short of SPAWN_END so a terminator never qualifies.
  always_ff @(posedge Clk or negedge Reset_n) begin : scroll_track
    if (!Reset_n) begin
      scroll_col <= '0;
    end else if (level_start && !kill_all) begin
      scroll_col <= '0;
    end else if (Shift && (state != IDLE) && (scroll_col < SCROLL_MAX)) begin
      scroll_col <= scroll_col + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin : spawn_fsm
    if (!Reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      slot       <= '0;
      pend       <= '0;
      timer      <= '0;
      start      <= '0;
      kill       <= '0;
      spawnX     <= '0;
      spawnY     <= '0;
      table_done <= 1'b0;
      spawn_err  <= 1'b0;
    end else begin
      start <= '0;
      kill  <= '0;
      if (kill_all) begin
        kill       <= '1;
        pend       <= '0;
        table_done <= 1'b0;
        state      <= IDLE;
      end else if (level_start) begin
        kill       <= '1;
        ptr        <= '0;
        pend       <= '0;
        table_done <= 1'b0;
        spawn_err  <= 1'b0;
        state      <= FETCH;
      end else begin
        unique case (state)
          IDLE, DONE: ;
          FETCH: state <= CHECK;
          CHECK: begin
            if (at_end) begin
              table_done <= 1'b1;
              state      <= DONE;
            end else if (!too_far && free_found) begin
              slot   <= free_idx;
              start  <= NUM_SLOTS'(1) << free_idx;
              spawnX <= SPAWN_X;
              spawnY <= entry.y;
              state  <= ISSUE;
            end
          end
          ISSUE: begin
            pend  <= start;
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (goomba_alive[slot]) begin
              ptr   <= ptr + ADDR_W'(1);
              pend  <= '0;
              state <= FETCH;
            end else if (timer == ACK_TIMEOUT) begin
              spawn_err <= 1'b1;
              ptr       <= ptr + ADDR_W'(1);
              pend      <= '0;
              state     <= FETCH;
            end else begin
              timer <= timer + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goomba_spawner.sv
// Directed bench for goomba_spawner: walks a six-entry level table through
// scroll gating, slot allocation, ack timeout, kill/restart and the kill tally.
module tb_goomba_spawner;
  import mario_pkg::*;

  // Entry 0 sits at the LSB end; entries 6..15 are terminators.
  localparam logic [16*18-1:0] TBL = {
    {10{8'hFF, 10'd0}},
    {8'd17, 10'd80},
    {8'd16, 10'd120},
    {8'd16, 10'd200},
    {8'd16, 10'd300},
    {8'd2,  10'd360},
    {8'd0,  10'd400}
  };

  logic       Clk;
  logic       Reset_n;
  logic       level_start;
  logic       kill_all;
  logic       Shift;
  logic [3:0] goomba_alive;
  logic [3:0] goomba_killed;
  logic [3:0] start;
  logic [3:0] kill;
  logic [9:0] spawnX;
  logic [9:0] spawnY;
  logic [7:0] kill_count;
  logic       table_done;
  logic       spawn_err;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;
  logic got;

  goomba_spawner #(
    .TABLE_INIT (TBL)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .level_start   (level_start),
    .kill_all      (kill_all),
    .Shift         (Shift),
    .goomba_alive  (goomba_alive),
    .goomba_killed (goomba_killed),
    .start         (start),
    .kill          (kill),
    .spawnX        (spawnX),
    .spawnY        (spawnY),
    .kill_count    (kill_count),
    .table_done    (table_done),
    .spawn_err     (spawn_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // Returns the number of negedges until start!=0, or 0 if none within max_cyc.
  task automatic wait_start(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (n == 0) begin
        @(negedge Clk);
        if (start != 4'b0000) n = i;
      end
    end
  endtask

  task automatic pulse_level(input string tag);
    level_start = 1'b1;
    @(negedge Clk);
    check_val(tag, 32'(kill), 32'hF);
    level_start = 1'b0;
  endtask

  task automatic pulse_shift();
    Shift = 1'b1;
    @(negedge Clk);
    Shift = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset_n       = 1'b0;
    level_start   = 1'b0;
    kill_all      = 1'b0;
    Shift         = 1'b0;
    goomba_alive  = 4'b0000;
    goomba_killed = 4'b0000;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    check_val("rst_start", 32'(start), 0);
    check_val("rst_kill", 32'(kill), 0);
    check_val("rst_spawnX", 32'(spawnX), 0);
    check_val("rst_spawnY", 32'(spawnY), 0);
    check_val("rst_kill_count", 32'(kill_count), 0);
    check_val("rst_table_done", 32'(table_done), 0);
    check_val("rst_spawn_err", 32'(spawn_err), 0);

    // Entries 0 and 1 spawn back to back into slots 0 and 1.
    pulse_level("ls1_kill");
    wait_start(4, waited);
    check_val("e0_latency", 32'(waited), 2);
    check_val("e0_start", 32'(start), 32'h1);
    check_val("e0_spawnX", 32'(spawnX), 519);
    check_val("e0_spawnY", 32'(spawnY), 400);
    goomba_alive = 4'b0001;
    @(negedge Clk);
    check_val("e0_one_cycle", 32'(start), 0);
    wait_start(6, waited);
    check_val("e1_latency", 32'(waited), 3);
    check_val("e1_start", 32'(start), 32'h2);
    check_val("e1_spawnY", 32'(spawnY), 360);
    goomba_alive = 4'b0011;

    // Entry 2 at col 16 must wait for scroll 6.
    repeat (5) pulse_shift();
    wait_start(4, waited);
    check_val("e2_held_scroll5", 32'(waited), 0);
    pulse_shift();
    wait_start(3, waited);
    check_val("e2_latency", 32'(waited), 1);
    check_val("e2_start", 32'(start), 32'h4);
    check_val("e2_spawnY", 32'(spawnY), 300);

    // Entry 3 eligible but every slot busy until slot 2 drops.
    goomba_alive = 4'b1111;
    wait_start(6, waited);
    check_val("e3_no_free_slot", 32'(waited), 0);
    goomba_alive = 4'b1011;
    wait_start(3, waited);
    check_val("e3_latency", 32'(waited), 1);
    check_val("e3_start", 32'(start), 32'h4);
    check_val("e3_spawnY", 32'(spawnY), 200);

    // Slot 2 never comes alive: error after the full timeout, table moves on.
    repeat (9) @(negedge Clk);
    check_val("err_not_early", 32'(spawn_err), 0);
    @(negedge Clk);
    check_val("err_set", 32'(spawn_err), 1);
    wait_start(4, waited);
    check_val("e4_latency", 32'(waited), 2);
    check_val("e4_start", 32'(start), 32'h4);
    check_val("e4_spawnY", 32'(spawnY), 120);

    // Entry 5 at col 17: scroll 7 makes it eligible, slots full until slot 0 frees.
    goomba_alive = 4'b1111;
    pulse_shift();
    wait_start(5, waited);
    check_val("e5_no_free_slot", 32'(waited), 0);
    goomba_alive = 4'b1110;
    wait_start(3, waited);
    check_val("e5_latency", 32'(waited), 1);
    check_val("e5_start", 32'(start), 32'h1);
    check_val("e5_spawnY", 32'(spawnY), 80);
    goomba_alive = 4'b1111;

    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        @(negedge Clk);
        got = table_done;
      end
    end
    check_val("table_done", 32'(got), 1);
    check_val("err_sticky", 32'(spawn_err), 1);
    pulse_shift();
    wait_start(3, waited);
    check_val("done_no_start", 32'(waited), 0);
    check_val("done_held", 32'(table_done), 1);

    // Squish tally, including saturation with a multi-bit increment.
    goomba_killed = 4'b0011;
    @(negedge Clk);
    check_val("kc_two", 32'(kill_count), 2);
    goomba_killed = 4'b0001;
    repeat (100) @(negedge Clk);
    check_val("kc_102", 32'(kill_count), 102);
    repeat (200) @(negedge Clk);
    check_val("kc_sat", 32'(kill_count), 255);
    goomba_killed = 4'b1111;
    @(negedge Clk);
    check_val("kc_sat_no_wrap", 32'(kill_count), 255);
    goomba_killed = 4'b0000;

    // Second level: restart clears done/err, then kill_all while waiting.
    goomba_alive = 4'b0000;
    pulse_level("ls2_kill");
    check_val("ls2_err_clr", 32'(spawn_err), 0);
    check_val("ls2_done_clr", 32'(table_done), 0);
    wait_start(4, waited);
    check_val("ls2_latency", 32'(waited), 2);
    check_val("ls2_start", 32'(start), 32'h1);
    repeat (2) @(negedge Clk);
    kill_all = 1'b1;
    @(negedge Clk);
    check_val("ka_kill", 32'(kill), 32'hF);
    check_val("ka_start", 32'(start), 0);
    kill_all = 1'b0;
    @(negedge Clk);
    check_val("ka_kill_one_cycle", 32'(kill), 0);
    wait_start(12, waited);
    check_val("ka_idle_no_start", 32'(waited), 0);
    check_val("ka_kc_kept", 32'(kill_count), 255);

    // Simultaneous kill_all and level_start: restart is dropped.
    kill_all    = 1'b1;
    level_start = 1'b1;
    @(negedge Clk);
    check_val("ka_ls_kill", 32'(kill), 32'hF);
    kill_all    = 1'b0;
    level_start = 1'b0;
    wait_start(6, waited);
    check_val("ka_ls_ignored", 32'(waited), 0);

    // Asynchronous reset in the middle of WAIT.
    pulse_level("ls3_kill");
    wait_start(4, waited);
    check_val("ls3_start", 32'(start), 32'h1);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_spawnY", 32'(spawnY), 0);
    check_val("arst_spawnX", 32'(spawnX), 0);
    check_val("arst_kill_count", 32'(kill_count), 0);
    check_val("arst_start", 32'(start), 0);
    check_val("arst_kill", 32'(kill), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_start(4, waited);
    check_val("post_rst_idle", 32'(waited), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
